// File: rtl/tick_monitor_pkg.sv
// Shared definitions for the tick monitor: FSM state encoding and err_flags bit positions.
package tick_monitor_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int EARLY   = 0;
    localparam int LATE    = 1;
    localparam int MISSING = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus history flop; emits a registered one-cycle pulse per rising edge.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic meta_reg;
    logic sync_reg;
    logic hist_reg;

    // The pulse is registered so downstream sees a clean flop output, at the cost of one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            hist_reg <= 1'b0;
            rise     <= 1'b0;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
            hist_reg <= sync_reg;
            rise     <= sync_reg & ~hist_reg;
        end
    end

endmodule

// File: rtl/tick_monitor.sv
// Measures the period of an asynchronous tick, classifies it against a tolerance window,
// tracks lock and flags early, late and missing ticks.
module tick_monitor
    import tick_monitor_pkg::*;
#(
    parameter int unsigned NOMINAL_COUNT = 25_000_000,
    parameter int unsigned TOLERANCE     = 500,
    parameter int unsigned LOCK_COUNT    = 4,
    parameter int unsigned TIMEOUT_COUNT = 2 * NOMINAL_COUNT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_in,
    input  logic        clear_err,
    output logic [31:0] period,
    output logic        period_valid,
    output logic        locked,
    output logic        early_err,
    output logic        late_err,
    output logic        missing_err,
    output logic [2:0]  err_flags
);

    localparam logic [31:0] LO_LIMIT = 32'(NOMINAL_COUNT - TOLERANCE);
    localparam logic [31:0] HI_LIMIT = 32'(NOMINAL_COUNT + TOLERANCE);
    localparam logic [31:0] TMO      = 32'(TIMEOUT_COUNT);
    localparam logic [31:0] LK       = 32'(LOCK_COUNT);

    state_t      state_reg;
    logic [31:0] cnt_reg;
    logic [31:0] good_cnt_reg;
    logic        tick_rise;
    logic [31:0] meas;
    logic        is_early;
    logic        is_late;
    logic        ev_early;
    logic        ev_late;
    logic        ev_missing;
    logic [2:0]  flags_next;

    sync_edge_detect u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (tick_in),
        .rise  (tick_rise)
    );

    assign meas     = cnt_reg + 32'd1;
    assign is_early = meas < LO_LIMIT;
    assign is_late  = meas > HI_LIMIT;

    // An edge in the timeout cycle wins: it is measured (and will classify as late).
    always_comb begin
        ev_early   = 1'b0;
        ev_late    = 1'b0;
        ev_missing = 1'b0;
        if (state_reg != HUNT) begin
            if (tick_rise) begin
                ev_early = is_early;
                ev_late  = is_late;
            end else if (cnt_reg == TMO) begin
                ev_missing = 1'b1;
            end
        end
    end

    always_comb begin
        flags_next          = clear_err ? 3'b000 : err_flags;
        flags_next[EARLY]   = flags_next[EARLY]   | ev_early;
        flags_next[LATE]    = flags_next[LATE]    | ev_late;
        flags_next[MISSING] = flags_next[MISSING] | ev_missing;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= HUNT;
            cnt_reg      <= 32'd0;
            good_cnt_reg <= 32'd0;
            period       <= 32'd0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            early_err    <= 1'b0;
            late_err     <= 1'b0;
            missing_err  <= 1'b0;
            err_flags    <= 3'b000;
        end else begin
            period_valid <= 1'b0;
            early_err    <= ev_early;
            late_err     <= ev_late;
            missing_err  <= ev_missing;
            err_flags    <= flags_next;
            case (state_reg)
                HUNT: begin
                    if (tick_rise) begin
                        state_reg    <= MEASURE;
                        cnt_reg      <= 32'd0;
                        good_cnt_reg <= 32'd0;
                    end
                end
                MEASURE, LOCKED: begin
                    if (tick_rise) begin
                        cnt_reg      <= 32'd0;
                        period       <= meas;
                        period_valid <= 1'b1;
                        if (is_early || is_late) begin
                            state_reg    <= MEASURE;
                            good_cnt_reg <= 32'd0;
                            locked       <= 1'b0;
                        end else if (state_reg == MEASURE) begin
                            good_cnt_reg <= good_cnt_reg + 32'd1;
                            if (good_cnt_reg + 32'd1 >= LK) begin
                                state_reg <= LOCKED;
                                locked    <= 1'b1;
                            end
                        end
                    end else if (cnt_reg == TMO) begin
                        state_reg    <= HUNT;
                        good_cnt_reg <= 32'd0;
                        locked       <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
                default: begin
                    state_reg <= HUNT;
                    locked    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/tick_monitor.md
TICK_MONITOR -- requirements
Module: tick_monitor

Interface
REQ-001 Parameter NOMINAL_COUNT, default 25_000_000, expected tick period in clk cycles.
REQ-002 Parameter TOLERANCE, default 500, allowed +/- deviation in clk cycles.
REQ-003 Parameter LOCK_COUNT, default 4, consecutive good periods needed to declare lock.
REQ-004 Parameter TIMEOUT_COUNT, default 2*NOMINAL_COUNT, cycles without an edge before a tick is declared missing.
REQ-005 The clock port SHALL be clk  input  1  the single clock; all logic on its rising edge.
REQ-006 The reset port SHALL be rst_n  input  1  reset, asynchronous, active-low.
REQ-007 tick_in  input  1  asynchronous periodic pulse or level (e.g. LED enable); only rising edges are meaningful.
REQ-008 clear_err  input  1  synchronous clear of err_flags.
REQ-009 period  output  32  last measured period in clk cycles.
REQ-010 period_valid  output  1  one-cycle strobe; period updated this cycle.
REQ-011 locked  output  1  high while in LOCKED state.
REQ-012 early_err, late_err, missing_err  output  1 each  one-cycle event strobes.
REQ-013 err_flags  output  3  sticky {missing, late, early}.

Function
REQ-014 tick_in SHALL pass a 2-flop synchronizer plus one history flop; a detected edge is sync=1 & history=0.
REQ-015 Registered outputs for an edge SHALL appear exactly 3 clk cycles after the first clk edge sampling tick_in high.
REQ-016 tick_in held high indefinitely SHALL produce exactly one edge; pulse width SHALL NOT affect the measurement.
REQ-017 Counter cnt (32 bits) SHALL clear to 0 on each edge and otherwise increment; measured period P = cnt+1 at the edge.
REQ-018 Classification: good if NOMINAL_COUNT-TOLERANCE <= P <= NOMINAL_COUNT+TOLERANCE; early if below; late if above.
REQ-019 States: HUNT (no reference edge), MEASURE (reference edge held, not locked), LOCKED.
REQ-020 HUNT + edge -> MEASURE, cnt=0, good_cnt=0; no period_valid, no classification.
REQ-021 MEASURE + edge: period_valid=1, period=P; good -> good_cnt++, entering LOCKED in the same cycle good_cnt reaches LOCK_COUNT; early/late -> strobe, good_cnt=0, stay MEASURE.
REQ-022 LOCKED + good edge -> stay; LOCKED + early/late edge -> strobe, MEASURE, good_cnt=0, locked falls in the same cycle as period_valid.
REQ-023 MEASURE or LOCKED with cnt == TIMEOUT_COUNT and no edge -> missing_err, HUNT, good_cnt=0, locked=0; cnt holds in HUNT.
REQ-024 An edge in the cycle cnt == TIMEOUT_COUNT SHALL take priority: measured and classified as late, no missing_err.
REQ-025 At most one of early_err/late_err/missing_err SHALL be asserted in any cycle.
REQ-026 err_flags bits SHALL set on the matching strobe and clear only on clear_err; set SHALL win over simultaneous clear_err.
REQ-027 period SHALL hold its value between period_valid strobes.

Reset
REQ-028 rst_n low SHALL asynchronously force state=HUNT, cnt=0, good_cnt=0, synchronizer/history flops=0, period=0, and all 1-bit outputs and err_flags to 0.
REQ-029 Reset mid-period SHALL discard the partial count; the first edge after release SHALL be treated as a HUNT edge.
REQ-030 Reset release SHALL be synchronous to clk in the using design; the block SHALL NOT contain a reset synchronizer.

Structure
REQ-031 A shared package tick_monitor_pkg SHALL hold the state enum (HUNT, MEASURE, LOCKED) and the err_flags bit indices (EARLY=0, LATE=1, MISSING=2).
REQ-032 Synchronizer and edge detector SHALL be one sub-module, sync_edge_detect, reusable by other tick consumers.

Verification (NOMINAL_COUNT=100, TOLERANCE=2, LOCK_COUNT=3, TIMEOUT_COUNT=200)
REQ-033 Reset asserted mid-count, then released -> all outputs 0, first subsequent edge gives no period_valid.
REQ-034 Ticks every 100 cycles, 10 cycles high -> first edge no strobe; period=100 on every later edge; locked rises with the 3rd good period.
REQ-035 While locked, one period of 97 -> early_err pulse, err_flags=3'b001, locked falls; period of 103 -> late_err, err_flags=3'b011.
REQ-036 Ticks stop (or tick_in stuck high) -> missing_err exactly 200 cycles after last edge, state HUNT, next edge gives no period_valid.
REQ-037 Edge arriving exactly at cnt==200 -> period=201, late_err, no missing_err.
REQ-038 clear_err coincident with a new early_err -> err_flags[0] stays 1; clear_err alone -> err_flags=0.
